// File: rtl/keypad_scanner_if.sv
// Keypad bundle between the matrix pins, the scanner and the downstream consumer.
// The master side (the scanner) senses rows, drives columns and publishes key codes.
interface keypad_scanner_if;
  logic [3:0] keypad_row;
  logic [2:0] keypad_col;
  logic [3:0] keypad_input;
  logic       keypad_valid;

  modport master (
    input  keypad_row,
    output keypad_col,
    output keypad_input,
    output keypad_valid
  );

  modport slave (
    output keypad_row,
    input  keypad_col,
    input  keypad_input,
    input  keypad_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, 2-flop row synchroniser, per-frame
// decode and a press/release debounce FSM that emits one code pulse per key press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int RELEASE_FRAMES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int             DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DF_L       = 4'(DEBOUNCE_FRAMES);
  localparam logic [3:0]     RF_L       = 4'(RELEASE_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  // Matrix position index is row*3+col; '*' and '#' map to E and F.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'h1;
      4'd1:    key_code = 4'h2;
      4'd2:    key_code = 4'h3;
      4'd3:    key_code = 4'h4;
      4'd4:    key_code = 4'h5;
      4'd5:    key_code = 4'h6;
      4'd6:    key_code = 4'h7;
      4'd7:    key_code = 4'h8;
      4'd8:    key_code = 4'h9;
      4'd9:    key_code = 4'hE;
      4'd10:   key_code = 4'h0;
      4'd11:   key_code = 4'hF;
      default: key_code = 4'h0;
    endcase
  endfunction

  function automatic logic [2:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = 3'b110;
      2'd1:    col_drive = 3'b101;
      2'd2:    col_drive = 3'b011;
      default: col_drive = 3'b110;
    endcase
  endfunction

  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    col_idx_q;
  logic [DW-1:0] dwell_q;
  logic [2:0]    col_q;
  logic [3:0]    samp0_q, samp1_q;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic          valid_q;
  logic [3:0]    code_q;

  logic          sample_s, frame_done_s;
  logic [1:0]    col_next_s;
  logic [3:0]    low_s;
  logic [11:0]   hits_s;
  logic          frame_none_s, frame_single_s;
  logic [3:0]    frame_code_s;
  logic          emit_s;

  assign sample_s     = (dwell_q == DWELL_LAST);
  assign frame_done_s = sample_s && (col_idx_q == 2'd2);
  assign col_next_s   = (col_idx_q == 2'd2) ? 2'd0 : (col_idx_q + 2'd1);
  assign low_s        = ~row_s2_q;

  // Row synchroniser; idle (pulled-up) value after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= kp.keypad_row;
      row_s2_q <= row_s1_q;
    end
  end

  // Column strobe and dwell counter; rows are captured on the last dwell cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      col_q     <= 3'b110;
      samp0_q   <= 4'h0;
      samp1_q   <= 4'h0;
    end else begin
      if (sample_s) begin
        dwell_q   <= '0;
        col_idx_q <= col_next_s;
        col_q     <= col_drive(col_next_s);
      end else begin
        dwell_q   <= dwell_q + DW'(1);
      end
      if (sample_s && (col_idx_q == 2'd0)) samp0_q <= low_s;
      if (sample_s && (col_idx_q == 2'd1)) samp1_q <= low_s;
    end
  end

  // Frame decode; column 2 is taken live so the result is ready on frame_done.
  always_comb begin
    hits_s       = 12'h000;
    frame_code_s = 4'h0;
    for (int r = 0; r < 4; r++) begin
      hits_s[r*3]     = samp0_q[r];
      hits_s[r*3 + 1] = samp1_q[r];
      hits_s[r*3 + 2] = low_s[r];
    end
    for (int i = 0; i < 12; i++) begin
      frame_code_s = hits_s[i] ? key_code(4'(i)) : frame_code_s;
    end
    frame_none_s   = (hits_s == 12'h000);
    frame_single_s = ($countones(hits_s) == 1);
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= 4'h0;
      rcnt_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Debounce FSM next-state; MULTI frames break both press and release runs.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    emit_s  = 1'b0;
    if (frame_done_s) begin
      case (state_q)
        S_IDLE: begin
          if (frame_single_s) begin
            cand_d = frame_code_s;
            if (DF_L == 4'd1) begin
              state_d = S_PRESSED;
              cnt_d   = DF_L;
              emit_s  = 1'b1;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        S_DEBOUNCE: begin
          if (frame_single_s && (frame_code_s == cand_q)) begin
            if ((cnt_q + 4'd1) >= DF_L) begin
              state_d = S_PRESSED;
              cnt_d   = DF_L;
              emit_s  = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (frame_single_s) begin
            cand_d = frame_code_s;
            cnt_d  = 4'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end
        S_PRESSED: begin
          if (frame_none_s) begin
            if (RF_L == 4'd1) begin
              state_d = S_IDLE;
              rcnt_d  = 4'd0;
            end else begin
              state_d = S_RELEASE;
              rcnt_d  = 4'd1;
            end
          end else begin
            state_d = S_PRESSED;
          end
        end
        S_RELEASE: begin
          if (frame_none_s) begin
            if ((rcnt_q + 4'd1) >= RF_L) begin
              state_d = S_IDLE;
              rcnt_d  = 4'd0;
            end else begin
              rcnt_d = rcnt_q + 4'd1;
            end
          end else begin
            state_d = S_PRESSED;
            rcnt_d  = 4'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          rcnt_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output register: one-cycle pulse, code held until the next accepted press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      code_q  <= 4'h0;
    end else begin
      valid_q <= emit_s;
      if (emit_s) code_q <= frame_code_s;
    end
  end

  assign kp.keypad_col   = col_q;
  assign kp.keypad_input = code_q;
  assign kp.keypad_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed frame-level stimulus for keypad_scanner with a run-length
// reference model feeding a scoreboard queue; a monitor checks pulses, codes and columns.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 2;
  localparam int RF = 2;
  localparam int FL = 3 * SD;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [11:0] mask;
  logic [11:0] plan [0:63];
  logic [3:0]  last_code;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  exp_t        exp_q [$];

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF),
    .RELEASE_FRAMES  (RF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int key_idx(input logic [3:0] code);
    case (code)
      4'h1: key_idx = 0;   4'h2: key_idx = 1;   4'h3: key_idx = 2;
      4'h4: key_idx = 3;   4'h5: key_idx = 4;   4'h6: key_idx = 5;
      4'h7: key_idx = 6;   4'h8: key_idx = 7;   4'h9: key_idx = 8;
      4'hE: key_idx = 9;   4'h0: key_idx = 10;  4'hF: key_idx = 11;
      default: key_idx = 10;
    endcase
  endfunction

  function automatic logic [3:0] idx_code(input int i);
    logic [3:0] c;
    c = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (key_idx(4'(k)) == i) c = 4'(k);
    end
    return c;
  endfunction

  function automatic logic [11:0] kmask(input logic [3:0] code);
    logic [11:0] m;
    m = 12'h000;
    m[key_idx(code)] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] exp_col(input int c);
    case ((c / SD) % 3)
      0:       exp_col = 3'b110;
      1:       exp_col = 3'b101;
      default: exp_col = 3'b011;
    endcase
  endfunction

  // Physical matrix: a pressed key shorts its row to the currently driven column.
  always_comb begin
    logic [3:0] row;
    int         c;
    row = 4'hF;
    case (kif.keypad_col)
      3'b110:  c = 0;
      3'b101:  c = 1;
      3'b011:  c = 2;
      default: c = 3;
    endcase
    for (int r = 0; r < 4; r++) begin
      if (c < 3 && mask[r*3 + c]) row[r] = 1'b0;
    end
    kif.keypad_row = row;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor: column sequence every cycle, pulses against the scoreboard, held code.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_cmp++;
      if (kif.keypad_col !== exp_col(cyc)) begin
        n_bad++;
        $display("FAIL col cyc=%0d got=%b want=%b", cyc, kif.keypad_col, exp_col(cyc));
      end
      if (kif.keypad_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse cyc=%0d code=%h want no pulse", cyc, kif.keypad_input);
        end else begin
          e = exp_q.pop_front();
          if (kif.keypad_input !== e.code || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL pulse got code=%h cyc=%0d want code=%h cyc=%0d",
                     kif.keypad_input, cyc, e.code, e.cyc);
          end
          last_code = e.code;
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_pulse cyc=%0d got valid=%b want pulse code=%h", cyc,
                 kif.keypad_valid, e.code);
      end
      n_cmp++;
      if (kif.keypad_input !== last_code) begin
        n_bad++;
        $display("FAIL held_code cyc=%0d got=%h want=%h", cyc, kif.keypad_input, last_code);
      end
    end
  end

  // Reference: a key is accepted when armed and it has been the sole key for DF
  // consecutive frames; re-arming needs RF consecutive empty frames.
  task automatic model_phase(input int nf);
    bit   armed;
    int   run, run_key, none_run, pc;
    exp_t e;
    armed = 1'b1; run = 0; run_key = -1; none_run = 0;
    for (int f = 0; f < nf; f++) begin
      pc = $countones(plan[f]);
      if (pc == 1) begin
        int k;
        k = 0;
        for (int i = 0; i < 12; i++) if (plan[f][i]) k = i;
        if (run > 0 && run_key == k) run++;
        else begin run = 1; run_key = k; end
        none_run = 0;
      end else if (pc == 0) begin
        run = 0;
        none_run++;
      end else begin
        run = 0;
        none_run = 0;
      end
      if (armed && pc == 1 && run == DF) begin
        e.code = idx_code(run_key);
        e.cyc  = (f + 1) * FL;
        exp_q.push_back(e);
        armed = 1'b0;
      end else if (!armed && none_run >= RF) begin
        armed = 1'b1;
      end
    end
  endtask

  task automatic run_phase(input int nf, input logic [11:0] tail_mask, input int tail_cycles);
    @(negedge clk); #1;
    rst = 1'b0;
    #2;
    n_cmp += 3;
    if (kif.keypad_col !== 3'b110) begin
      n_bad++; $display("FAIL reset_col got=%b want=110", kif.keypad_col);
    end
    if (kif.keypad_input !== 4'h0) begin
      n_bad++; $display("FAIL reset_input got=%h want=0", kif.keypad_input);
    end
    if (kif.keypad_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got=%b want=0", kif.keypad_valid);
    end
    exp_q.delete();
    last_code = 4'h0;
    model_phase(nf);
    @(negedge clk); #1;
    rst = 1'b1;
    for (int f = 0; f < nf; f++) begin
      mask = plan[f];
      repeat (FL) @(negedge clk);
      #1;
    end
    mask = tail_mask;
    repeat (tail_cycles) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got=%0d pending pulses want=0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; mask = 12'h000; last_code = 4'h0;
    for (int i = 0; i < 64; i++) plan[i] = 12'h000;
    repeat (2) @(negedge clk);

    // '5' held 10 frames: single pulse, no repeat.
    for (int f = 0; f < 10; f++) plan[f] = kmask(4'h5);
    run_phase(10, 12'h000, FL + 2);

    // '8' bounce: present, absent, present, present.
    plan[0] = kmask(4'h8); plan[1] = 12'h000; plan[2] = kmask(4'h8); plan[3] = kmask(4'h8);
    run_phase(4, 12'h000, FL + 2);

    // '*' then three empty frames then '#'.
    for (int f = 0; f < 3; f++) plan[f]     = kmask(4'hE);
    for (int f = 3; f < 6; f++) plan[f]     = 12'h000;
    for (int f = 6; f < 9; f++) plan[f]     = kmask(4'hF);
    run_phase(9, 12'h000, FL + 2);

    // '1' and '6' together, then '6' dropped.
    for (int f = 0; f < 5; f++) plan[f] = kmask(4'h1) | kmask(4'h6);
    for (int f = 5; f < 8; f++) plan[f] = kmask(4'h1);
    run_phase(8, 12'h000, FL + 2);

    // '3' held, reset right after the first matching frame, then re-debounced.
    plan[0] = kmask(4'h3);
    run_phase(1, kmask(4'h3), 1);
    for (int f = 0; f < 4; f++) plan[f] = kmask(4'h3);
    run_phase(4, 12'h000, FL + 2);

    // Random segments of empty, single and multi-key frames.
    for (int p = 0; p < 6; p++) begin
      int f;
      f = 0;
      while (f < 24) begin
        int          kind, len;
        logic [11:0] m;
        kind = $urandom_range(0, 9);
        len  = $urandom_range(1, 4);
        if (kind < 4) begin
          m = 12'h000;
        end else if (kind < 9) begin
          m = 12'h000;
          m[$urandom_range(0, 11)] = 1'b1;
        end else begin
          int a, b;
          a = $urandom_range(0, 11);
          b = (a + $urandom_range(1, 11)) % 12;
          m = 12'h000;
          m[a] = 1'b1;
          m[b] = 1'b1;
        end
        for (int j = 0; j < len && f < 24; j++) begin
          plan[f] = m;
          f++;
        end
      end
      run_phase(24, 12'h000, FL + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
